down_timer: RTL
===============

# down_timer

Programmable countdown timer: the down-counting counterpart of the lab's enable-driven up counter. It loads an unsigned start value and decrements once every PRESCALE clock cycles while running. It flags expiry with a one-cycle terminal-count pulse and either stops or auto-reloads. It sits beside the up counter in the lab datapath as the time-base/interval source feeding the HEX display and sequencing logic.

## Interface

Parameters:
- WIDTH, 8, width of the count and load value.
- PRESCALE, 4, clock cycles per decrement; legal range ≥1; 1 means decrement every cycle.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clock clk.
- load  input  1  load load_value into count and the reload register; abort any run.
- load_value  input  WIDTH  unsigned start/reload value.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting while running.
- auto_reload  input  1  on expiry, reload and keep running instead of stopping.
- count  output  WIDTH  current count, registered.
- running  output  1  high while in RUN, registered.
- done  output  1  high while in DONE, registered.
- tc_pulse  output  1  one-cycle expiry pulse, registered.

## Operation

- States: IDLE, RUN, PAUSED, DONE.
- Internal registers: reload_reg (WIDTH bits) and prescaler (max(1,$clog2(PRESCALE)) bits).
- reset: count=0, reload_reg=0, prescaler=0, state=IDLE, running=0, done=0, tc_pulse=0. reset overrides all other inputs.
- Input priority per edge: reset > load > start > pause.
- load, in any state:
  - count←load_value, reload_reg←load_value, prescaler←0, state←IDLE.
  - tc_pulse←0.
  - start and pause in the same cycle are ignored.
- start:
  - IDLE: goes to RUN if count≠0; ignored if count=0.
  - PAUSED: goes to RUN; prescaler resumes from its held value.
  - DONE: if reload_reg≠0, count←reload_reg, prescaler←0, state←RUN; ignored if reload_reg=0.
  - RUN: no effect.
- pause:
  - RUN: goes to PAUSED; count and prescaler are held.
  - Any other state: no effect. If start and pause are both high in PAUSED, start wins.
- RUN, each edge:
  - If prescaler=PRESCALE−1: prescaler←0 and a step occurs.
  - Otherwise: prescaler←prescaler+1.
- Step:
  - count>1: count←count−1.
  - count=1 (expiry): tc_pulse←1 on this edge.
    - auto_reload=1 (sampled at the expiry edge): count←reload_reg, stay in RUN.
    - auto_reload=0: count←0, state←DONE.
- tc_pulse is high only in the cycle after an expiry edge; it is 0 on all other edges.
- Arithmetic: unsigned; count never wraps below 0. A zero count is never decremented.

## Timing

- The edge that samples start (call it E0) sets running=1; prescaler=0 on entry to RUN.
- First decrement occurs at edge E0+PRESCALE; each later decrement follows PRESCALE edges later.
- Non-reload expiry from load value N≥1: edge E0+N·PRESCALE gives count=0, done=1, running=0 and tc_pulse=1, all visible in the same cycle.
- Auto-reload from value N: tc_pulse fires every N·PRESCALE cycles. Count sequence per step is N, N−1, …, 1, N, …
- Cycles spent in PAUSED do not advance the prescaler. Total RUN edges to expiry is unchanged by pausing.
- load or reset in the middle of a run takes effect at the next edge.
  - The expiry pulse is suppressed if load or reset coincides with the expiry edge.
- With PRESCALE=1, the step occurs on every RUN edge. Expiry from N is at E0+N.

## Test plan

- Reset: hold reset 3 cycles, with load/start toggling -> count=0, running=0, done=0, tc_pulse=0 throughout and after release.
- One-shot, PRESCALE=4: load 5, start at E0 -> count 4 at E0+4, 3 at E0+8, …, 0 at E0+20. At E0+20, done=1, running=0 and tc_pulse high for exactly one cycle. Count stays 0 afterwards.
- Auto-reload: auto_reload=1, load 3, start -> tc_pulse every 12 cycles. Count steps 3,2,1,3,2,1. running stays 1 and done stays 0.
- Pause/resume: load 5, start at E0, pause at E0+6 (count=4, prescaler=2), hold 10 cycles -> count stays 4 and there is no tc_pulse. Start again -> expiry 14 RUN edges after resume, for 20 RUN edges total.
- Load/start rules:
  - Load 9 during RUN -> IDLE, count=9, running=0.
  - load+start in the same cycle -> IDLE (load wins).
  - Start with count=0 -> stays IDLE.
  - Start in DONE with reload_reg=5 -> count=5, RUN.
- Reset mid-run and PRESCALE=1 build:
  - Reset asserted at E0+7 -> all outputs 0 next cycle.
  - With PRESCALE=1, load 2, start -> count 1 at E0+1 and 0 at E0+2, with done and tc_pulse at E0+2.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: programmable countdown timer with prescaler, pause/resume,
// one-cycle terminal-count pulse and optional auto-reload on expiry.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             tc_pulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  // Next-state logic: load aborts everything, then per-state start/pause/count handling.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (count_q != '0)) begin
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_PAUSED: begin
          // Prescaler keeps its held phase so pausing never shortens or stretches the run.
          if (start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start && (reload_q != '0)) begin
            count_d = reload_q;
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State and datapath registers; reset clears everything to an idle zero count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      tc_q      <= tc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;

endmodule
